// File: rtl/add_8bit_opseq.sv
// Operand sequencer and result capture around the combinational ADD_8bit adder.
// Optional carry capture enabled by defining ADD8_OPSEQ_CARRY_EN.
module add_8bit_opseq #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic [W-1:0] add_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_carry,
    output logic [7:0]   op_count
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   ld_a, ld_b, cap, acc;
    logic   in_ready_nxt, out_valid_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle enables; flush overrides every transition.
    always_comb begin
        state_nxt     = state;
        ld_a          = 1'b0;
        ld_b          = 1'b0;
        cap           = 1'b0;
        acc           = 1'b0;
        case (state)
            S_A: begin
                if (in_valid) begin
                    ld_a      = 1'b1;
                    state_nxt = S_B;
                end
            end
            S_B: begin
                if (in_valid) begin
                    ld_b      = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                cap       = 1'b1;
                state_nxt = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    acc       = 1'b1;
                    state_nxt = S_A;
                end
            end
            default: state_nxt = S_A;
        endcase
        if (flush) begin
            state_nxt = S_A;
            ld_a      = 1'b0;
            ld_b      = 1'b0;
            cap       = 1'b0;
            acc       = 1'b0;
        end
        in_ready_nxt  = (state_nxt == S_A) || (state_nxt == S_B);
        out_valid_nxt = (state_nxt == S_OUT);
    end

    // Handshake flags are flopped copies of the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a    <= '0;
            add_b    <= '0;
            out_data <= '0;
            op_count <= '0;
        end else begin
            if (ld_a) add_a <= in_data;
            if (ld_b) add_b <= in_data;
            if (cap)  out_data <= add_result;
            if (acc)  op_count <= op_count + CNT_W'(1);
        end
    end

`ifdef ADD8_OPSEQ_CARRY_EN
    // A wrapped 8-bit sum is smaller than either operand.
    logic carry_c;
    assign carry_c = (add_result < add_a);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_carry <= 1'b0;
        end else if (cap) begin
            out_carry <= carry_c;
        end
    end
`else
    assign out_carry = 1'b0;
`endif

endmodule
